// File: rtl/img_mem_arbiter.sv
// Round-robin arbiter sharing one single-port image memory between the pixel
// engine (port 0) and the host/readout port (port 1), with a bounded ownership lock.
module img_mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt0,
  output logic [15:0]       stall_cnt1
);

  // Handshake: reqN is a valid that stays high until gntN; an access transfers
  // in the cycle where reqN and gntN are both high. gntN acts as the ready.

  logic              owner;
  logic [3:0]        lock_cnt;
  logic [15:0]       stall0_q;
  logic [15:0]       stall1_q;

  logic              both;
  logic              lock_own;
  logic              keep_owner;
  logic              any_gnt;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              relock;

  always_comb begin
    both       = req0 & req1;
    lock_own   = owner ? lock1 : lock0;
    keep_owner = lock_own && (int'(lock_cnt) < MAX_LOCK);
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (!reset) begin
      if (both) begin
        // Under contention the owner keeps the memory only while its lock budget lasts.
        gnt0 = keep_owner ? ~owner : owner;
        gnt1 = keep_owner ?  owner : ~owner;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    any_gnt = gnt0 | gnt1;
    g_we    = gnt1 ? we1    : we0;
    g_addr  = gnt1 ? addr1  : addr0;
    g_wdata = gnt1 ? wdata1 : wdata0;
    relock  = any_gnt && both && lock_own && (gnt1 == owner);
  end

  assign rdata0     = mem_rdata;
  assign rdata1     = mem_rdata;
  assign stall_cnt0 = stall0_q;
  assign stall_cnt1 = stall1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      owner     <= 1'b1;
      lock_cnt  <= 4'd0;
      stall0_q  <= 16'd0;
      stall1_q  <= 16'd0;
    end else begin
      mem_wr  <= any_gnt & g_we;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (any_gnt) begin
        mem_addr <= g_addr;
        owner    <= gnt1;
        if (g_we) mem_wdata <= g_wdata;
      end
      lock_cnt <= relock ? 4'(lock_cnt + 4'd1) : 4'd0;
      if (req0 && !gnt0 && stall0_q != 16'hFFFF) stall0_q <= 16'(stall0_q + 16'd1);
      if (req1 && !gnt1 && stall1_q != 16'hFFFF) stall1_q <= 16'(stall1_q + 16'd1);
    end
  end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Bench for img_mem_arbiter: a behavioural memory macro, a reference memory
// and per-port expected-read queues checked whenever rvalid fires.
module tb_img_mem_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1, lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_wr;
  logic [DATA_W-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       stall_cnt0, stall_cnt1;

  logic [DATA_W-1:0] mem     [1<<ADDR_W];
  logic [DATA_W-1:0] ref_mem [1<<ADDR_W];
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  logic              exp_rv0 = 1'b0;
  logic              exp_rv1 = 1'b0;
  int                n_checks = 0;
  int                n_fail = 0;

  img_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
  );

  // clock / memory macro
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  // scoreboard: every read grant must produce exactly one rvalid one cycle later
  always @(negedge clk) begin
    n_checks++;
    if (rvalid0 !== exp_rv0) begin
      n_fail++;
      $display("FAIL sb_rvalid0: got %b expected %b at %0t", rvalid0, exp_rv0, $time);
    end
    if (rvalid0 === 1'b1 && exp_rv0 && exp_q0.size() > 0) begin
      logic [DATA_W-1:0] e0;
      e0 = exp_q0.pop_front();
      n_checks++;
      if (rdata0 !== e0) begin
        n_fail++;
        $display("FAIL sb_rdata0: got %h expected %h at %0t", rdata0, e0, $time);
      end
    end
    n_checks++;
    if (rvalid1 !== exp_rv1) begin
      n_fail++;
      $display("FAIL sb_rvalid1: got %b expected %b at %0t", rvalid1, exp_rv1, $time);
    end
    if (rvalid1 === 1'b1 && exp_rv1 && exp_q1.size() > 0) begin
      logic [DATA_W-1:0] e1;
      e1 = exp_q1.pop_front();
      n_checks++;
      if (rdata1 !== e1) begin
        n_fail++;
        $display("FAIL sb_rdata1: got %h expected %h at %0t", rdata1, e1, $time);
      end
    end
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks: entered at a falling edge with inputs already set
  task automatic tick(output logic g0, output logic g1);
    #1;
    g0 = gnt0;
    g1 = gnt1;
    if (g0 === 1'b1) begin
      if (we0) ref_mem[addr0] = wdata0;
      else begin exp_q0.push_back(ref_mem[addr0]); exp_rv0 = 1'b1; end
    end
    if (g1 === 1'b1) begin
      if (we1) ref_mem[addr1] = wdata1;
      else begin exp_q1.push_back(ref_mem[addr1]); exp_rv1 = 1'b1; end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic rand_port0();
    we0 = 1'($urandom_range(0, 1));
    addr0 = ADDR_W'($urandom_range(0, 31));
    wdata0 = DATA_W'($urandom_range(0, 255));
  endtask

  task automatic rand_port1();
    we1 = 1'($urandom_range(0, 1));
    addr1 = ADDR_W'($urandom_range(0, 31));
    wdata1 = DATA_W'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    logic g0, g1;
    idle_inputs();
    reset = 1;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 2; i++) begin
      tick(g0, g1);
      n_checks++;
      if (g0 !== 1'b0 || g1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_gnt: got %b%b expected 00", g0, g1);
      end
    end
    idle_inputs();
    reset = 0;
    tick(g0, g1);
    n_checks++;
    if (mem_wr !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got wr=%b addr=%h wdata=%h expected 0/0/0", mem_wr, mem_addr, mem_wdata);
    end
    n_checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || stall_cnt0 !== 16'd0 || stall_cnt1 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got rv=%b%b stall=%h/%h expected 00 0000/0000", rvalid0, rvalid1, stall_cnt0, stall_cnt1);
    end
  endtask

  task automatic test_single_read();
    logic g0, g1;
    req0 = 1; we0 = 1; addr0 = 14'h0081; wdata0 = 8'h5A;
    tick(g0, g1);
    n_checks++;
    if (g0 !== 1'b1 || g1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_wr_gnt: got %b%b expected 10", g0, g1);
    end
    n_checks++;
    if (mem_wr !== 1'b1 || mem_addr !== 14'h0081 || mem_wdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL single_wr_mem: got wr=%b addr=%h wdata=%h expected 1/0081/5a", mem_wr, mem_addr, mem_wdata);
    end
    we0 = 0;
    tick(g0, g1);
    n_checks++;
    if (g0 !== 1'b1 || g1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rd_gnt: got %b%b expected 10", g0, g1);
    end
    n_checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h5A || stall_cnt0 !== 16'd0) begin
      n_fail++;
      $display("FAIL single_rd_data: got rv=%b data=%h stall=%h expected 1/5a/0000", rvalid0, rdata0, stall_cnt0);
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    logic g0, g1, e0;
    // a lone port-1 access makes port 1 the owner, so port 0 wins first
    req1 = 1; we1 = 1; addr1 = 14'h0005; wdata1 = 8'hC3;
    tick(g0, g1);
    n_checks++;
    if (g1 !== 1'b1 || g0 !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_prep_gnt: got %b%b expected 01", g0, g1);
    end
    for (int i = 0; i < 6; i++) begin
      req0 = 1; req1 = 1; lock0 = 0; lock1 = 0;
      rand_port0();
      rand_port1();
      tick(g0, g1);
      e0 = (i % 2 == 0);
      n_checks++;
      if (g0 !== e0 || g1 !== ~e0) begin
        n_fail++;
        $display("FAIL contention_gnt[%0d]: got %b%b expected %b%b", i, g0, g1, e0, ~e0);
      end
    end
    idle_inputs();
    n_checks++;
    if (stall_cnt0 !== 16'd3 || stall_cnt1 !== 16'd3) begin
      n_fail++;
      $display("FAIL contention_stall: got %0d/%0d expected 3/3", stall_cnt0, stall_cnt1);
    end
  endtask

  task automatic test_bounded_lock();
    logic g0, g1, e1;
    req0 = 1; we0 = 0; addr0 = 14'h0081;
    tick(g0, g1);
    n_checks++;
    if (g0 !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_prep_gnt: got %b expected 1", g0);
    end
    // two full lock windows: 8 owner grants, one hand-over, then the restarted window
    for (int i = 0; i < 19; i++) begin
      req0 = 1; req1 = 1; lock0 = 1; lock1 = 0;
      rand_port0();
      rand_port1();
      tick(g0, g1);
      e1 = (i == 8 || i == 18);
      n_checks++;
      if (g1 !== e1 || g0 !== ~e1) begin
        n_fail++;
        $display("FAIL lock_gnt[%0d]: got %b%b expected %b%b", i, g0, g1, ~e1, e1);
      end
    end
    idle_inputs();
    n_checks++;
    if (stall_cnt0 !== 16'd5 || stall_cnt1 !== 16'd20) begin
      n_fail++;
      $display("FAIL lock_stall: got %0d/%0d expected 5/20", stall_cnt0, stall_cnt1);
    end
  endtask

  task automatic test_raw_back_to_back();
    logic g0, g1;
    req1 = 1; we1 = 1; addr1 = 14'h3FFF; wdata1 = 8'h33;
    tick(g0, g1);
    n_checks++;
    if (g1 !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_wr_gnt: got %b expected 1", g1);
    end
    idle_inputs();
    req0 = 1; we0 = 0; addr0 = 14'h3FFF;
    tick(g0, g1);
    n_checks++;
    if (g0 !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_rd_gnt: got %b expected 1", g0);
    end
    n_checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h33 || rvalid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_data: got rv0=%b data=%h rv1=%b expected 1/33/0", rvalid0, rdata0, rvalid1);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    logic g0, g1;
    req1 = 1; we1 = 0; addr1 = 14'h1234;
    tick(g0, g1);
    n_checks++;
    if (g1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre_gnt: got %b expected 1", g1);
    end
    addr1 = 14'h2000;
    reset = 1;
    tick(g0, g1);
    n_checks++;
    if (g0 !== 1'b0 || g1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_gnt: got %b%b expected 00", g0, g1);
    end
    n_checks++;
    if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got rv=%b%b wr=%b addr=%h wdata=%h expected all 0", rvalid0, rvalid1, mem_wr, mem_addr, mem_wdata);
    end
    n_checks++;
    if (stall_cnt0 !== 16'd0 || stall_cnt1 !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid_stall: got %0d/%0d expected 0/0", stall_cnt0, stall_cnt1);
    end
    reset = 0;
    req0 = 1; we0 = 0; addr0 = 14'h0081;
    req1 = 1; we1 = 0; addr1 = 14'h0005;
    tick(g0, g1);
    n_checks++;
    if (g0 !== 1'b1 || g1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_first_contention: got %b%b expected 10", g0, g1);
    end
    idle_inputs();
  endtask

  task automatic test_stall_saturation();
    logic g0, g1;
    force dut.stall1_q = 16'hFFFE;
    #1;
    release dut.stall1_q;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req0 = 1; lock0 = 1; req1 = 1; lock1 = 0;
      we0 = 0; we1 = 0; addr0 = 14'h3FFF; addr1 = 14'h0005;
      tick(g0, g1);
      n_checks++;
      if (g0 !== 1'b1 || g1 !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_gnt[%0d]: got %b%b expected 10", i, g0, g1);
      end
      n_checks++;
      if (stall_cnt1 !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL sat_stall1[%0d]: got %h expected ffff", i, stall_cnt1);
      end
    end
    idle_inputs();
    n_checks++;
    if (stall_cnt0 !== 16'd0) begin
      n_fail++;
      $display("FAIL sat_stall0: got %h expected 0000", stall_cnt0);
    end
  endtask

  initial begin
    logic g0, g1;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_contention();
    test_bounded_lock();
    test_raw_back_to_back();
    test_reset_mid_read();
    test_stall_saturation();
    tick(g0, g1);
    tick(g0, g1);
    n_checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d/%0d pending reads expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
